// File: rtl/dmem_lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
// The execute stage is the master; dmem_lsu is the slave.
interface dmem_lsu_if;
  logic        REQ;
  logic        WE;
  logic [1:0]  SIZE;
  logic        UNSIGNED;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [31:0] RDATA;

  modport master (
    output REQ, WE, SIZE, UNSIGNED, ADDR, WDATA,
    input  BUSY, DONE, ERR, RDATA
  );

  modport slave (
    input  REQ, WE, SIZE, UNSIGNED, ADDR, WDATA,
    output BUSY, DONE, ERR, RDATA
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW onto a word-wide
// RDEN/WEN data memory; sub-word stores use read-modify-write.
module dmem_lsu #(
  parameter int unsigned ADDR_DEPTH = 14
) (
  input  logic                  CLK,
  input  logic                  RST,
  dmem_lsu_if.slave             cpu,
  output logic                  MEM_RDEN,
  output logic                  MEM_WEN,
  output logic [1:0]            MEM_BYTE_SEL,
  output logic                  MEM_SIGN,
  output logic [ADDR_DEPTH-1:0] MEM_ADDR,
  output logic [31:0]           MEM_DIN,
  input  logic [31:0]           MEM_DOUT
);

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_CAP,
    RMW_RD,
    RMW_MRG,
    ST_WR
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t state, state_nx;

  logic [ADDR_DEPTH+1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [15:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [31:0]           din_q;
  logic                  done_q;
  logic                  err_q;

  logic                  req_illegal;
  logic                  accept;
  logic                  done_nx;
  logic                  err_nx;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           load_val;
  logic [31:0]           merge_val;

  // Upper address bits are dropped: accesses wrap modulo the memory size.
  logic unused_addr;
  assign unused_addr = ^cpu.ADDR[31:ADDR_DEPTH+2];

  assign req_illegal = (cpu.SIZE == 2'b11)
                     | ((cpu.SIZE == SZ_HALF) & cpu.ADDR[0])
                     | ((cpu.SIZE == SZ_WORD) & (|cpu.ADDR[1:0]));
  assign accept      = (state == IDLE) & cpu.REQ & ~req_illegal;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    MEM_RDEN = 1'b0;
    MEM_WEN  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu.REQ) begin
          if (req_illegal) begin
            done_nx = 1'b1;
            err_nx  = 1'b1;
          end else if (!cpu.WE) begin
            state_nx = LD_RD;
          end else if (cpu.SIZE == SZ_WORD) begin
            state_nx = ST_WR;
          end else begin
            state_nx = RMW_RD;
          end
        end
      end
      LD_RD: begin
        MEM_RDEN = 1'b1;
        state_nx = LD_CAP;
      end
      LD_CAP: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD: begin
        MEM_RDEN = 1'b1;
        state_nx = RMW_MRG;
      end
      RMW_MRG: begin
        state_nx = ST_WR;
      end
      ST_WR: begin
        MEM_WEN  = 1'b1;
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Lane extraction and extension of the word returned for a load.
  always_comb begin
    ld_byte = MEM_DOUT[7:0];
    unique case (addr_q[1:0])
      2'd0: ld_byte = MEM_DOUT[7:0];
      2'd1: ld_byte = MEM_DOUT[15:8];
      2'd2: ld_byte = MEM_DOUT[23:16];
      2'd3: ld_byte = MEM_DOUT[31:24];
      default: ld_byte = MEM_DOUT[7:0];
    endcase
    ld_half = addr_q[1] ? MEM_DOUT[31:16] : MEM_DOUT[15:0];

    unique case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_val = MEM_DOUT;
    endcase
  end

  // Merge for sub-word stores: only the addressed lane takes new data.
  always_comb begin
    merge_val = MEM_DOUT;
    if (size_q == SZ_BYTE) begin
      unique case (addr_q[1:0])
        2'd0: merge_val[7:0]   = wdata_q[7:0];
        2'd1: merge_val[15:8]  = wdata_q[7:0];
        2'd2: merge_val[23:16] = wdata_q[7:0];
        2'd3: merge_val[31:24] = wdata_q[7:0];
        default: merge_val = MEM_DOUT;
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q;
    end else begin
      merge_val[15:0] = wdata_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= done_nx;
      err_q  <= err_nx;
      if (accept) begin
        addr_q  <= cpu.ADDR[ADDR_DEPTH+1:0];
        size_q  <= cpu.SIZE;
        uns_q   <= cpu.UNSIGNED;
        wdata_q <= cpu.WDATA[15:0];
        if (cpu.WE && cpu.SIZE == SZ_WORD) din_q <= cpu.WDATA;
      end
      if (state == LD_CAP)  rdata_q <= load_val;
      if (state == RMW_MRG) din_q   <= merge_val;
    end
  end

  assign cpu.BUSY    = (state != IDLE);
  assign cpu.DONE    = done_q;
  assign cpu.ERR     = err_q;
  assign cpu.RDATA   = rdata_q;
  assign MEM_ADDR     = addr_q[ADDR_DEPTH+1:2];
  assign MEM_DIN      = din_q;
  assign MEM_BYTE_SEL = 2'b10;
  assign MEM_SIGN     = 1'b0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu against a behavioural word memory with a
// one-cycle read latency and zero read data when not enabled.
module tb_dmem_lsu;
  localparam int unsigned AD = 14;

  logic          CLK;
  logic          RST;
  logic          MEM_RDEN, MEM_WEN, MEM_SIGN;
  logic [1:0]    MEM_BYTE_SEL;
  logic [AD-1:0] MEM_ADDR;
  logic [31:0]   MEM_DIN, MEM_DOUT;

  logic [31:0]   mem [0:(1<<AD)-1];
  logic          pre_we;
  logic [AD-1:0] pre_addr;
  logic [31:0]   pre_data;

  int checks = 0;
  int failures = 0;

  int          r_done_at, r_rden_at, r_wen_at, r_rden_cnt, r_wen_cnt;
  logic        r_err, r_overlap;
  logic [31:0] r_din;
  logic [AD-1:0] r_addr;

  dmem_lsu_if bus();

  dmem_lsu #(.ADDR_DEPTH(AD)) dut (
    .CLK(CLK), .RST(RST), .cpu(bus),
    .MEM_RDEN(MEM_RDEN), .MEM_WEN(MEM_WEN), .MEM_BYTE_SEL(MEM_BYTE_SEL),
    .MEM_SIGN(MEM_SIGN), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (MEM_WEN) mem[MEM_ADDR] <= MEM_DIN;
    MEM_DOUT <= MEM_RDEN ? mem[MEM_ADDR] : 32'd0;
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic preload(input logic [AD-1:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Issue one request at the current negedge and record strobes up to DONE.
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.REQ = 1'b1; bus.WE = we; bus.SIZE = size; bus.UNSIGNED = uns;
    bus.ADDR = addr; bus.WDATA = wdata;
    tick();
    bus.REQ = 1'b0;
    r_done_at = -1; r_rden_at = -1; r_wen_at = -1; r_rden_cnt = 0; r_wen_cnt = 0;
    r_err = 1'b0; r_overlap = 1'b0; r_din = '0; r_addr = '0;
    for (int c = 1; c <= 10; c++) begin
      if (MEM_RDEN) begin
        r_rden_cnt++; r_addr = MEM_ADDR;
        if (r_rden_at < 0) r_rden_at = c;
      end
      if (MEM_WEN) begin
        r_wen_cnt++; r_wen_at = c; r_din = MEM_DIN; r_addr = MEM_ADDR;
      end
      if (MEM_RDEN && MEM_WEN) r_overlap = 1'b1;
      if (bus.DONE) begin
        r_done_at = c; r_err = bus.ERR;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.REQ = 1'b0; bus.WE = 1'b0; bus.SIZE = 2'b00; bus.UNSIGNED = 1'b0;
    bus.ADDR = '0; bus.WDATA = '0;
    tick();
    preload(14'd1, 32'h8899AABB);
    preload(14'd2, 32'h0);
    preload(14'd3, 32'h11111111);
    checks++; if (bus.BUSY !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
    checks++; if (bus.ERR !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", bus.ERR); end
    checks++; if (bus.RDATA !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.RDATA); end
    checks++; if ({MEM_RDEN, MEM_WEN} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {MEM_RDEN, MEM_WEN}); end
    checks++; if (MEM_ADDR !== '0)     begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", MEM_ADDR); end
    checks++; if (MEM_DIN !== 32'd0)   begin failures++; $display("FAIL reset_mem_din got=%h exp=0", MEM_DIN); end
    checks++; if (MEM_BYTE_SEL !== 2'b10) begin failures++; $display("FAIL reset_byte_sel got=%b exp=10", MEM_BYTE_SEL); end
    checks++; if (MEM_SIGN !== 1'b0)   begin failures++; $display("FAIL reset_sign got=%b exp=0", MEM_SIGN); end
    RST = 1'b0;
    tick();
    checks++; if ({bus.BUSY, bus.DONE} !== 2'b00) begin failures++; $display("FAIL post_reset_idle got=%b exp=00", {bus.BUSY, bus.DONE}); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
    logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [6] = '{32'd5, 32'd7, 32'd6, 32'd4, 32'd4, 32'd4};
    logic [31:0] exp [6] = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899,
                             32'h8899AABB, 32'h0000AABB, 32'hFFFFFFBB};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, sz[i], un[i], ad[i], 32'h0);
      checks++; if (r_done_at !== 3) begin failures++; $display("FAIL load%0d_done_cycle got=%0d exp=3", i, r_done_at); end
      checks++; if (bus.RDATA !== exp[i]) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", i, bus.RDATA, exp[i]); end
      checks++; if ({r_rden_at, r_wen_cnt, r_err} !== {32'sd1, 32'sd0, 1'b0}) begin
        failures++; $display("FAIL load%0d_strobes rden_at=%0d wen=%0d err=%b exp 1/0/0", i, r_rden_at, r_wen_cnt, r_err);
      end
    end
  endtask

  task automatic test_subword_store();
    do_op(1'b1, 2'b00, 1'b0, 32'd5, 32'h00000012);
    checks++; if (r_rden_at !== 1) begin failures++; $display("FAIL sb_rden_cycle got=%0d exp=1", r_rden_at); end
    checks++; if (r_wen_at !== 3)  begin failures++; $display("FAIL sb_wen_cycle got=%0d exp=3", r_wen_at); end
    checks++; if (r_din !== 32'h889912BB) begin failures++; $display("FAIL sb_din got=%h exp=889912BB", r_din); end
    checks++; if (r_done_at !== 4) begin failures++; $display("FAIL sb_done_cycle got=%0d exp=4", r_done_at); end
    checks++; if (r_overlap !== 1'b0) begin failures++; $display("FAIL sb_overlap got=%b exp=0", r_overlap); end
    do_op(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000CAFE);
    checks++; if (r_din !== 32'hCAFE12BB) begin failures++; $display("FAIL sh_din got=%h exp=CAFE12BB", r_din); end
    checks++; if (mem[1] !== 32'hCAFE12BB) begin failures++; $display("FAIL sh_mem got=%h exp=CAFE12BB", mem[1]); end
    do_op(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    checks++; if (bus.RDATA !== 32'hCAFE12BB) begin failures++; $display("FAIL sh_readback got=%h exp=CAFE12BB", bus.RDATA); end
  endtask

  task automatic test_word_store();
    do_op(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF);
    checks++; if (r_rden_cnt !== 0) begin failures++; $display("FAIL sw_rden_count got=%0d exp=0", r_rden_cnt); end
    checks++; if (r_wen_at !== 1)   begin failures++; $display("FAIL sw_wen_cycle got=%0d exp=1", r_wen_at); end
    checks++; if (r_din !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_din got=%h exp=DEADBEEF", r_din); end
    checks++; if (r_addr !== 14'd2) begin failures++; $display("FAIL sw_mem_addr got=%0d exp=2", r_addr); end
    checks++; if (r_done_at !== 2)  begin failures++; $display("FAIL sw_done_cycle got=%0d exp=2", r_done_at); end
    do_op(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    checks++; if (bus.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_readback got=%h exp=DEADBEEF", bus.RDATA); end
  endtask

  task automatic test_illegal();
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'd6, 32'd3, 32'd4};
    for (int i = 0; i < 3; i++) begin
      do_op(we[i], sz[i], 1'b0, ad[i], 32'h5A5A5A5A);
      checks++; if (r_done_at !== 1) begin failures++; $display("FAIL illegal%0d_done_cycle got=%0d exp=1", i, r_done_at); end
      checks++; if (r_err !== 1'b1)  begin failures++; $display("FAIL illegal%0d_err got=%b exp=1", i, r_err); end
      checks++; if (r_rden_cnt + r_wen_cnt !== 0) begin failures++; $display("FAIL illegal%0d_strobes got=%0d exp=0", i, r_rden_cnt + r_wen_cnt); end
      checks++; if (bus.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL illegal%0d_rdata got=%h exp=DEADBEEF", i, bus.RDATA); end
    end
  endtask

  task automatic test_wrap();
    do_op(1'b0, 2'b10, 1'b0, 32'd65540, 32'h0);
    checks++; if (r_addr !== 14'd1) begin failures++; $display("FAIL wrap_mem_addr got=%0d exp=1", r_addr); end
    checks++; if (bus.RDATA !== 32'hCAFE12BB) begin failures++; $display("FAIL wrap_rdata got=%h exp=CAFE12BB", bus.RDATA); end
  endtask

  task automatic test_busy_req();
    int wen_seen = 0;
    bus.REQ = 1'b1; bus.WE = 1'b0; bus.SIZE = 2'b10; bus.ADDR = 32'd4;
    tick();
    bus.REQ = 1'b1; bus.WE = 1'b1; bus.SIZE = 2'b10; bus.ADDR = 32'd12; bus.WDATA = 32'h55555555;
    if (MEM_WEN) wen_seen++;
    tick();
    bus.REQ = 1'b0;
    if (MEM_WEN) wen_seen++;
    tick();
    checks++; if (bus.DONE !== 1'b1) begin failures++; $display("FAIL busy_req_done got=%b exp=1", bus.DONE); end
    checks++; if (bus.RDATA !== 32'hCAFE12BB) begin failures++; $display("FAIL busy_req_rdata got=%h exp=CAFE12BB", bus.RDATA); end
    tick();
    if (MEM_WEN) wen_seen++;
    checks++; if ({bus.BUSY, bus.DONE} !== 2'b00) begin failures++; $display("FAIL busy_req_idle got=%b exp=00", {bus.BUSY, bus.DONE}); end
    checks++; if (wen_seen !== 0 || mem[3] !== 32'h11111111) begin
      failures++; $display("FAIL busy_req_ignored wen=%0d mem3=%h exp 0/11111111", wen_seen, mem[3]);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
    checks++; if (bus.RDATA !== 32'hCAFE12BB) begin failures++; $display("FAIL b2b_first got=%h exp=CAFE12BB", bus.RDATA); end
    do_op(1'b0, 2'b10, 1'b0, 32'd8, 32'h0);
    checks++; if (r_done_at !== 3) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=3", r_done_at); end
    checks++; if (bus.RDATA !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_second got=%h exp=DEADBEEF", bus.RDATA); end
  endtask

  task automatic test_reset_mid();
    bus.REQ = 1'b1; bus.WE = 1'b1; bus.SIZE = 2'b00; bus.ADDR = 32'd5; bus.WDATA = 32'h77;
    tick();
    bus.REQ = 1'b0;
    checks++; if (MEM_RDEN !== 1'b1) begin failures++; $display("FAIL rst_mid_rmw_rd got=%b exp=1", MEM_RDEN); end
    tick();
    RST = 1'b1;
    tick();
    checks++; if ({bus.BUSY, bus.DONE, MEM_WEN, MEM_RDEN} !== 4'b0000) begin
      failures++; $display("FAIL rst_mid_ctrl got=%b exp=0000", {bus.BUSY, bus.DONE, MEM_WEN, MEM_RDEN});
    end
    checks++; if ({bus.RDATA, MEM_DIN} !== 64'd0 || MEM_ADDR !== '0) begin
      failures++; $display("FAIL rst_mid_regs rdata=%h din=%h addr=%h exp 0", bus.RDATA, MEM_DIN, MEM_ADDR);
    end
    RST = 1'b0;
    tick();
    checks++; if (bus.DONE !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b exp=0", bus.DONE); end
    checks++; if (mem[1] !== 32'hCAFE12BB) begin failures++; $display("FAIL rst_mid_mem got=%h exp=CAFE12BB", mem[1]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loads();
    test_subword_store();
    test_word_store();
    test_illegal();
    test_wrap();
    test_busy_req();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
